// File: rtl/bram_if_pkg.sv
// Shared definitions for the BRAM reader/writer/controller family.
// Holds default port widths and the burst writer state encoding.
package bram_if_pkg;

    localparam int ADDRESS_WIDTH   = 13;
    localparam int BRAM_DATA_WIDTH = 32;
    localparam int PIX_WIDTH       = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        WRITE,
        DONE
    } writer_state_t;

endpackage

// File: rtl/bram_burst_writer_beat_unpacker.sv
// Holding register for one wide input beat plus a word selector that
// presents the idx-th BRAM-sized slice of it.
module bram_burst_writer_beat_unpacker #(
    parameter int DATA_WIDTH = 32,
    parameter int IN_WIDTH   = 512,
    parameter int WORDS      = IN_WIDTH / DATA_WIDTH,
    parameter int IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load,
    input  logic [IN_WIDTH-1:0]   beat_in,
    input  logic [IDX_W-1:0]      idx,
    output logic [DATA_WIDTH-1:0] word
);

    logic [IN_WIDTH-1:0]   beat_reg;
    logic [DATA_WIDTH-1:0] words [WORDS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_reg <= '0;
        end else if (load) begin
            beat_reg <= beat_in;
        end
    end

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_split
        assign words[gi] = beat_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Out-of-range idx can only occur for non power-of-two word counts; return 0.
    always_comb begin
        word = '0;
        if (32'(idx) < WORDS) begin
            word = words[idx];
        end
    end

endmodule

// File: rtl/bram_burst_writer.sv
// Accepts wide beats over valid/ready and writes them word by word to
// consecutive addresses of a single-port BRAM, pulsing finish when done.
module bram_burst_writer #(
    parameter int ADDRESS_WIDTH        = bram_if_pkg::ADDRESS_WIDTH,
    parameter int BRAM_DATA_WIDTH      = bram_if_pkg::BRAM_DATA_WIDTH,
    parameter int WRITER_DATA_IN_WIDTH = 512
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic [ADDRESS_WIDTH-1:0]        base_addr_i,
    input  logic [ADDRESS_WIDTH:0]          num_words_i,
    output logic                            busy_o,
    input  logic                            wr_valid_i,
    output logic                            wr_ready_o,
    input  logic [WRITER_DATA_IN_WIDTH-1:0] wr_data_i,
    output logic                            wr_finish_o,
    output logic [ADDRESS_WIDTH-1:0]        bram_addr,
    output logic                            bram_en,
    output logic                            bram_we,
    output logic [BRAM_DATA_WIDTH-1:0]      bram_data_in
);

    import bram_if_pkg::*;

    localparam int WORDS_PER_BEAT = WRITER_DATA_IN_WIDTH / BRAM_DATA_WIDTH;
    localparam int IDX_W          = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;

    writer_state_t            state_reg, state_next;
    logic [ADDRESS_WIDTH-1:0] base_reg, base_next;
    logic [ADDRESS_WIDTH:0]   num_reg, num_next;
    logic [ADDRESS_WIDTH:0]   cnt_reg, cnt_next;
    logic [IDX_W-1:0]         idx_reg, idx_next;
    logic [ADDRESS_WIDTH:0]   cnt_inc;
    logic                     load_beat;
    logic                     writing;
    logic [BRAM_DATA_WIDTH-1:0] sel_word;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            base_reg  <= '0;
            num_reg   <= '0;
            cnt_reg   <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            base_reg  <= base_next;
            num_reg   <= num_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
        end
    end

    assign cnt_inc = cnt_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        base_next  = base_reg;
        num_next   = num_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        load_beat  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    base_next  = base_addr_i;
                    num_next   = num_words_i;
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = (num_words_i == '0) ? DONE : ACCEPT;
                end
            end
            ACCEPT: begin
                if (wr_valid_i) begin
                    load_beat  = 1'b1;
                    idx_next   = '0;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                cnt_next = cnt_inc;
                idx_next = idx_reg + 1'b1;
                // Finishing mid-beat simply drops the rest of the holding register.
                if (cnt_inc == num_reg) begin
                    state_next = DONE;
                end else if (idx_reg == IDX_W'(WORDS_PER_BEAT - 1)) begin
                    state_next = ACCEPT;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    bram_burst_writer_beat_unpacker #(
        .DATA_WIDTH (BRAM_DATA_WIDTH),
        .IN_WIDTH   (WRITER_DATA_IN_WIDTH),
        .WORDS      (WORDS_PER_BEAT),
        .IDX_W      (IDX_W)
    ) u_unpacker (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (load_beat),
        .beat_in (wr_data_i),
        .idx     (idx_reg),
        .word    (sel_word)
    );

    // Every output is a decode of registered state, so reset clears them all at once.
    assign writing      = (state_reg == WRITE);
    assign busy_o       = (state_reg != IDLE);
    assign wr_ready_o   = (state_reg == ACCEPT);
    assign wr_finish_o  = (state_reg == DONE);
    assign bram_en      = writing;
    assign bram_we      = writing;
    assign bram_addr    = writing ? (base_reg + cnt_reg[ADDRESS_WIDTH-1:0]) : '0;
    assign bram_data_in = writing ? sel_word : '0;

endmodule

// File: tb/tb_bram_burst_writer.sv
// Bench for bram_burst_writer: directed and random bursts compared against
// an expected write list built from base, length and the beats sent.
module tb_bram_burst_writer;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [12:0]   base_addr_i;
    logic [13:0]   num_words_i;
    logic          busy_o;
    logic          wr_valid_i;
    logic          wr_ready_o;
    logic [511:0]  wr_data_i;
    logic          wr_finish_o;
    logic [12:0]   bram_addr;
    logic          bram_en;
    logic          bram_we;
    logic [31:0]   bram_data_in;

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor state (written only by the monitor process)
    int          cyc = 0;
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          fin_cnt = 0;
    int          fin_cyc = -10;
    int          ready_cnt = 0;
    int          viol_cnt = 0;
    logic        busy_at_fin = 1'b0;
    logic        busy_after = 1'b1;

    logic [511:0] beats[$];
    int           start_cyc;

    bram_burst_writer dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .num_words_i  (num_words_i),
        .busy_o       (busy_o),
        .wr_valid_i   (wr_valid_i),
        .wr_ready_o   (wr_ready_o),
        .wr_data_i    (wr_data_i),
        .wr_finish_o  (wr_finish_o),
        .bram_addr    (bram_addr),
        .bram_en      (bram_en),
        .bram_we      (bram_we),
        .bram_data_in (bram_data_in)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (bram_en && bram_we) begin
            wr_addr_q.push_back(int'(bram_addr));
            wr_data_q.push_back(bram_data_in);
            wr_cyc_q.push_back(cyc);
        end
        if (bram_en != bram_we) viol_cnt = viol_cnt + 1;
        if (wr_ready_o && bram_en) viol_cnt = viol_cnt + 1;
        if (wr_ready_o) ready_cnt = ready_cnt + 1;
        if (cyc == fin_cyc + 1) busy_after = busy_o;
        if (wr_finish_o) begin
            fin_cnt     = fin_cnt + 1;
            fin_cyc     = cyc;
            busy_at_fin = busy_o;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [511:0] rand_beat();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},   64'(busy_o), 0);
        check({tag, "_ready"},  64'(wr_ready_o), 0);
        check({tag, "_finish"}, 64'(wr_finish_o), 0);
        check({tag, "_en_we"},  64'({bram_en, bram_we}), 0);
        check({tag, "_addr"},   64'(bram_addr), 0);
        check({tag, "_data"},   64'(bram_data_in), 0);
    endtask

    // Send one beat, waiting a bounded time for ready.
    task automatic send_beat(input logic [511:0] b, input int gap, output bit ok);
        int t;
        repeat (gap) @(posedge clk_i);
        #1;
        wr_valid_i = 1'b1;
        wr_data_i  = b;
        t = 0;
        do begin
            @(negedge clk_i);
            t++;
        end while (!wr_ready_o && t < 300);
        ok = wr_ready_o;
        if (!ok) check("ready_timeout", 1, 0);
        @(posedge clk_i);
        #1;
        wr_valid_i = 1'b0;
    endtask

    task automatic pulse_start(input logic [12:0] base, input int len);
        @(posedge clk_i);
        #1;
        start_i     = 1'b1;
        base_addr_i = base;
        num_words_i = len[13:0];
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    task automatic run_burst(input string name, input logic [12:0] base, input int len, input int gap);
        int q0, f0, r0, v0, nb, nw, t, exp_fin;
        bit ok;
        logic [511:0] bt;
        q0 = wr_addr_q.size(); f0 = fin_cnt; r0 = ready_cnt; v0 = viol_cnt;
        pulse_start(base, len);
        start_cyc = cyc;
        nb = (len + 15) / 16;
        ok = 1'b1;
        for (int b = 0; b < nb && ok; b++) send_beat(beats[b], gap, ok);
        t = 0;
        while (fin_cnt == f0 && t < 300) begin
            @(posedge clk_i);
            t++;
        end
        repeat (3) @(posedge clk_i);
        nw = wr_addr_q.size() - q0;
        check({name, "_wr_count"}, 64'(nw), 64'(len));
        for (int k = 0; k < nw && k < len; k++) begin
            bt = beats[k / 16];
            check($sformatf("%s_w%0d_addr", name, k), 64'(wr_addr_q[q0+k]), 64'((int'(base) + k) % 8192));
            check($sformatf("%s_w%0d_data", name, k), 64'(wr_data_q[q0+k]), 64'(bt[(k % 16)*32 +: 32]));
            if (k % 16 != 0)
                check($sformatf("%s_w%0d_cyc", name, k), 64'(wr_cyc_q[q0+k]), 64'(wr_cyc_q[q0+k-1] + 1));
        end
        check({name, "_finish_count"}, 64'(fin_cnt - f0), 1);
        exp_fin = (len == 0) ? start_cyc : ((nw > 0) ? wr_cyc_q[q0+nw-1] + 1 : -1);
        check({name, "_finish_cycle"}, 64'(fin_cyc), 64'(exp_fin));
        check({name, "_busy_at_finish"}, 64'(busy_at_fin), 1);
        check({name, "_busy_after"}, 64'(busy_after), 0);
        check({name, "_protocol"}, 64'(viol_cnt - v0), 0);
        if (len == 0) check({name, "_ready_len0"}, 64'(ready_cnt - r0), 0);
        $display("burst %s base=0x%0h len=%0d gap=%0d writes=%0d", name, base, len, gap, nw);
    endtask

    task automatic reset_test();
        int q0, f0, t;
        bit ok;
        logic [511:0] bt;
        beats.delete();
        beats.push_back(rand_beat());
        bt = beats[0];
        q0 = wr_addr_q.size(); f0 = fin_cnt;
        pulse_start(13'h200, 16);
        send_beat(beats[0], 0, ok);
        t = 0;
        while (wr_addr_q.size() - q0 < 4 && t < 100) begin
            @(posedge clk_i);
            t++;
        end
        #1;
        start_i = 1'b1; base_addr_i = 13'h300; num_words_i = 14'd5;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        t = 0;
        while (wr_addr_q.size() - q0 < 8 && t < 100) begin
            @(posedge clk_i);
            t++;
        end
        #2;
        rst_i = 1'b1;
        #1;
        check_outputs_zero("async_rst");
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        check("rst_wr_count", 64'(wr_addr_q.size() - q0), 8);
        for (int k = 0; k < 8 && q0 + k < wr_addr_q.size(); k++) begin
            check($sformatf("rst_w%0d_addr", k), 64'(wr_addr_q[q0+k]), 64'(32'h200 + k));
            check($sformatf("rst_w%0d_data", k), 64'(wr_data_q[q0+k]), 64'(bt[k*32 +: 32]));
        end
        check("rst_no_finish", 64'(fin_cnt - f0), 0);
        $display("reset test: %0d words before reset", wr_addr_q.size() - q0);
        beats.delete();
        beats.push_back(rand_beat());
        run_burst("post_rst", 13'h040, 4, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] b;
        rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; num_words_i = '0;
        wr_valid_i = 1'b0; wr_data_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check_outputs_zero("reset");
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);

        beats.delete();
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = 32'(i);
        beats.push_back(b);
        run_burst("t1", 13'h100, 16, 0);

        beats.delete();
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = 32'(8'hA0 + i);
        beats.push_back(b);
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = 32'(8'hB0 + i);
        beats.push_back(b);
        run_burst("t2", 13'h000, 20, 0);

        beats.delete();
        run_burst("t3_len0", 13'h123, 0, 0);

        beats.delete();
        beats.push_back(rand_beat());
        run_burst("t4_wrap", 13'h1FF8, 16, 0);

        beats.delete();
        beats.push_back(rand_beat());
        beats.push_back(rand_beat());
        run_burst("t5_gap", 13'h055, 32, 5);

        reset_test();

        for (int r = 0; r < 10; r++) begin
            int len;
            len = $urandom_range(0, 40);
            beats.delete();
            for (int i = 0; i < (len + 15) / 16; i++) beats.push_back(rand_beat());
            run_burst($sformatf("rnd%0d", r), 13'($urandom), len, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
